vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Produces the raster timing that pixel renderers such as block_controller consume: hCount, vCount, bright, hSync, vSync.
- Also produces a once-per-frame tick that renderers can use as their slow update enable.
- Receives the renderer's rgb back and re-registers it, blanked outside the active area, so rgb_out and the sync outputs leave the block aligned.
- Default timing is 640x480 at 60 Hz from a 100 MHz clock with a /4 pixel enable. The active area spans (hCount,vCount) = (144,35) to (783,514).

Parameters:
CLK_DIV, 4, system clocks per pixel; must be at least 2
H_SYNC, 96, hSync pulse width in pixels
H_BP, 48, horizontal back porch
H_ACT, 640, active pixels per line
H_FP, 16, horizontal front porch
V_SYNC, 2, vSync pulse width in lines
V_BP, 33, vertical back porch
V_ACT, 480, active lines
V_FP, 10, vertical front porch

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous, active-high reset
rgb_in  in  12  renderer colour for the current (hCount,vCount)
hCount  out  10  horizontal counter, 0..H_TOTAL-1
vCount  out  10  vertical counter, 0..V_TOTAL-1
bright  out  1  high when the current counts are inside the active area
pix_en  out  1  one-clk strobe marking a pixel advance
frame_tick  out  1  one-clk pulse at frame wrap
hSync  out  1  active-low horizontal sync
vSync  out  1  active-low vertical sync
rgb_out  out  12  registered, blanked colour to the DAC pins

Behaviour:
- Derived values:
  - H_TOTAL = H_SYNC+H_BP+H_ACT+H_FP (default 800).
  - V_TOTAL = V_SYNC+V_BP+V_ACT+V_FP (default 525).
  - H_START = H_SYNC+H_BP; V_START = V_SYNC+V_BP.
- Reset: rst is sampled only on the clk rising edge. While rst is high, or on the cycle after it is sampled:
  - the divider counter is 0, hCount=0, vCount=0;
  - bright=0, pix_en=0, frame_tick=0, hSync=1, vSync=1, rgb_out=0.
- Reset mid-frame: aborts the frame immediately. No partial line is completed.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div==CLK_DIV-1), decoded combinationally from the div register.
  - First pix_en is high in the 4th clk after reset release (div=3).
- Counter advance, on a clk edge where pix_en=1:
  - If hCount==H_TOTAL-1: hCount<=0, and vCount<=(vCount==V_TOTAL-1) ? 0 : vCount+1.
  - Otherwise hCount<=hCount+1 and vCount holds.
  - With pix_en=0 the counters hold.
- bright:
  - Registered, and always consistent with the currently presented counts.
  - Computed from the next-count values: H_START<=h<H_START+H_ACT and V_START<=v<V_START+V_ACT.
  - Default active area is h 144..783, v 35..514.
- hSync, vSync, rgb_out:
  - Registered on pix_en edges from the pre-advance counts, so they lag hCount/vCount by exactly one pixel.
  - hSync = ~(hCount<H_SYNC).
  - vSync = ~(vCount<V_SYNC).
  - rgb_out = bright ? rgb_in : 0, using the pre-advance bright.
  - Between pix_en edges they hold.
- frame_tick:
  - Registered.
  - High for exactly one clk: the cycle following the edge where the counts wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Never asserted by reset.
- Width rules: the counters are 10 bits. H_TOTAL and V_TOTAL must be at most 1024; this is checked at elaboration and a violation fails elaboration.
- Timing:
  - One line = H_TOTAL*CLK_DIV clks (3200 by default).
  - One frame = H_TOTAL*V_TOTAL*CLK_DIV clks (1,680,000 by default, 59.52 Hz).
- rgb_in is sampled only on pix_en edges. Renderers may therefore decode it combinationally from hCount/vCount.

Test Plan:
- Reset release, defaults:
  - pix_en pulses exactly on clks 3, 7, 11, …
  - hCount steps 0→1 on the first pix_en edge.
  - hSync is 1 until the first pix_en edge, then 0.
- Full line:
  - hCount reaches 799, then returns to 0 while vCount increments.
  - hSync is low for exactly 96 pixels (384 clks), starting one pixel after hCount=0.
- Full frame:
  - frame_tick pulses once every 1,680,000 clks, each pulse 1 clk wide.
  - vSync is low for exactly 2 lines (6400 clks).
- Active window:
  - bright is 0 at (143,35), 1 at (144,35), 1 at (783,514), 0 at (784,514), and 0 at (144,515).
  - The count of bright pixels per frame is 307,200.
- Blanking and alignment:
  - rgb_in tied to 12'hFFF: rgb_out=12'hFFF only during the pixel after each bright pixel, 0 otherwise.
  - rgb_in=hCount[11:0]: rgb_out at pixel n equals the value of hCount at pixel n-1.
- Reset mid-frame:
  - Assert rst for 1 clk at (400,200).
  - Next cycle: all counts 0 and hSync=vSync=1, with no frame_tick pulse.
  - The following frame_tick arrives exactly 1,680,000 clks later.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable divider, h/v counters, active-area
// flag, sync pulses, frame tick and a blanked, sync-aligned colour register.
module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        frame_tick,
  output logic        hSync,
  output logic        vSync,
  output logic [11:0] rgb_out
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end

  // Active-area test done in int so H_START+H_ACT may equal 1024 safely.
  function automatic logic in_active(input logic [9:0] h, input logic [9:0] v);
    return (int'(h) >= H_START) && (int'(h) < H_START + H_ACT) &&
           (int'(v) >= V_START) && (int'(v) < V_START + V_ACT);
  endfunction

  logic [DIV_W-1:0] div;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             h_wrap;
  logic             v_wrap;

  assign pix_en = (div == DIV_W'(CLK_DIV - 1));

  // Next-count decode; bright is registered from these so it always matches
  // the counts presented on the same cycle.
  always_comb begin
    h_wrap = (hCount == 10'(H_TOTAL - 1));
    v_wrap = (vCount == 10'(V_TOTAL - 1));
    h_next = hCount;
    v_next = vCount;
    if (pix_en) begin
      if (h_wrap) begin
        h_next = 10'd0;
        v_next = v_wrap ? 10'd0 : vCount + 10'd1;
      end else begin
        h_next = hCount + 10'd1;
      end
    end
  end

  // Syncs and colour use the pre-advance counts, lagging the counters by one pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      div        <= '0;
      hCount     <= 10'd0;
      vCount     <= 10'd0;
      bright     <= 1'b0;
      frame_tick <= 1'b0;
      hSync      <= 1'b1;
      vSync      <= 1'b1;
      rgb_out    <= 12'h000;
    end else begin
      div        <= pix_en ? '0 : div + DIV_W'(1);
      frame_tick <= pix_en && h_wrap && v_wrap;
      if (pix_en) begin
        hCount  <= h_next;
        vCount  <= v_next;
        bright  <= in_active(h_next, v_next);
        hSync   <= ~(int'(hCount) < H_SYNC);
        vSync   <= ~(int'(vCount) < V_SYNC);
        rgb_out <= bright ? rgb_in : 12'h000;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: a default-timing instance for reset release and line timing, and a
// shrunken-timing instance for whole-frame, window, blanking and reset checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small timing for instance b: 17 x 9 pixels, CLK_DIV 2, frame = 306 clks.
  localparam int B_DIV = 2;
  localparam int B_HT = 17;
  localparam int B_VT = 9;
  localparam int B_FRAME = B_HT * B_VT * B_DIV;

  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic [11:0] rgb_a = 12'h000;
  logic        rgb_mode = 1'b0;
  logic [11:0] rgb_b;

  logic [9:0]  hc_a, vc_a, hc_b, vc_b;
  logic        br_a, pe_a, ft_a, hs_a, vs_a;
  logic        br_b, pe_b, ft_b, hs_b, vs_b;
  logic [11:0] ro_a, ro_b;

  assign rgb_b = rgb_mode ? {2'b00, hc_b} : 12'hFFF;

  vga_timing_gen u_a (
    .clk(clk), .rst(rst_a), .rgb_in(rgb_a),
    .hCount(hc_a), .vCount(vc_a), .bright(br_a), .pix_en(pe_a),
    .frame_tick(ft_a), .hSync(hs_a), .vSync(vs_a), .rgb_out(ro_a)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_SYNC(4), .H_BP(3), .H_ACT(8), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACT(4), .V_FP(1)
  ) u_b (
    .clk(clk), .rst(rst_b), .rgb_in(rgb_b),
    .hCount(hc_b), .vCount(vc_b), .bright(br_b), .pix_en(pe_b),
    .frame_tick(ft_b), .hSync(hs_b), .vSync(vs_b), .rgb_out(ro_b)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {int k; int pe; int h; int hs;} rel_vec_t;
  typedef struct {int h; int v; int br;} win_vec_t;
  rel_vec_t rel_tab[8];
  win_vec_t win_tab[5];
  int       win_seen[5];

  function automatic int bh(input int p); return p % B_HT; endfunction
  function automatic int bv(input int p); return (p / B_HT) % B_VT; endfunction
  function automatic int bact(input int h, input int v);
    return int'(h >= 7 && h < 15 && v >= 4 && v < 8);
  endfunction
  function automatic int brgb(input int p, input int sw);
    return (p < sw) ? 'hFFF : bh(p);
  endfunction

  // Cycle-accurate reference for instance b, cycle k counted from reset release.
  task automatic run_b(input int ncyc, input int sw, input int use_tab);
    int p, q, br_cyc, vs_low, ticks, exp_rgb;
    br_cyc = 0; vs_low = 0; ticks = 0;
    for (int k = 0; k < ncyc; k++) begin
      rgb_mode = (k >= B_DIV * sw);
      p = k / B_DIV;
      q = p - 1;
      exp_rgb = (p == 0) ? 0 : (bact(bh(q), bv(q)) != 0 ? brgb(q, sw) : 0);
      chk($sformatf("b_pix_en k=%0d", k), int'(pe_b), int'(k % B_DIV == B_DIV - 1));
      chk($sformatf("b_hCount k=%0d", k), int'(hc_b), bh(p));
      chk($sformatf("b_vCount k=%0d", k), int'(vc_b), bv(p));
      chk($sformatf("b_bright k=%0d", k), int'(br_b), bact(bh(p), bv(p)));
      chk($sformatf("b_hSync k=%0d", k), int'(hs_b), (p == 0) ? 1 : int'(bh(q) >= 4));
      chk($sformatf("b_vSync k=%0d", k), int'(vs_b), (p == 0) ? 1 : int'(bv(q) >= 2));
      chk($sformatf("b_rgb_out k=%0d", k), int'(ro_b), exp_rgb);
      chk($sformatf("b_frame_tick k=%0d", k), int'(ft_b), int'(k > 0 && k % B_FRAME == 0));
      if (use_tab != 0)
        for (int i = 0; i < 5; i++)
          if (win_seen[i] == 0 && int'(hc_b) == win_tab[i].h && int'(vc_b) == win_tab[i].v) begin
            win_seen[i] = 1;
            chk($sformatf("b_window (%0d,%0d)", win_tab[i].h, win_tab[i].v),
                int'(br_b), win_tab[i].br);
          end
      if (k < B_FRAME) begin
        br_cyc += int'(br_b);
        vs_low += int'(!vs_b);
      end
      ticks += int'(ft_b);
      @(negedge clk);
    end
    if (ncyc >= B_FRAME) begin
      chk("b_bright_pixels_per_frame", br_cyc / B_DIV, 32);
      chk("b_vsync_low_clks", vs_low, 2 * B_HT * B_DIV);
    end
    chk("b_tick_count", ticks, (ncyc - 1) / B_FRAME);
  endtask

  initial begin
    int hs_low, first_low, hmax, found;
    rel_tab[0] = '{0, 0, 0, 1};
    rel_tab[1] = '{2, 0, 0, 1};
    rel_tab[2] = '{3, 1, 0, 1};
    rel_tab[3] = '{4, 0, 1, 0};
    rel_tab[4] = '{7, 1, 1, 0};
    rel_tab[5] = '{8, 0, 2, 0};
    rel_tab[6] = '{11, 1, 2, 0};
    rel_tab[7] = '{12, 0, 3, 0};
    win_tab[0] = '{6, 4, 0};
    win_tab[1] = '{7, 4, 1};
    win_tab[2] = '{14, 7, 1};
    win_tab[3] = '{15, 7, 0};
    win_tab[4] = '{7, 8, 0};
    for (int i = 0; i < 5; i++) win_seen[i] = 0;

    repeat (3) @(negedge clk);
    chk("a_reset_hCount", int'(hc_a), 0);
    chk("a_reset_vCount", int'(vc_a), 0);
    chk("a_reset_pix_en", int'(pe_a), 0);
    chk("a_reset_bright", int'(br_a), 0);
    chk("a_reset_hSync", int'(hs_a), 1);
    chk("a_reset_vSync", int'(vs_a), 1);
    chk("a_reset_frame_tick", int'(ft_a), 0);
    chk("a_reset_rgb_out", int'(ro_a), 0);

    // Default-timing instance: release and watch the first line and a bit.
    rst_a = 1'b0;
    hs_low = 0; first_low = -1; hmax = 0;
    for (int k = 0; k < 3300; k++) begin
      if (k < 48) chk($sformatf("a_pix_en k=%0d", k), int'(pe_a), int'(k % 4 == 3));
      for (int i = 0; i < 8; i++)
        if (rel_tab[i].k == k) begin
          chk($sformatf("a_rel_pix_en k=%0d", k), int'(pe_a), rel_tab[i].pe);
          chk($sformatf("a_rel_hCount k=%0d", k), int'(hc_a), rel_tab[i].h);
          chk($sformatf("a_rel_hSync k=%0d", k), int'(hs_a), rel_tab[i].hs);
        end
      if (k < 3204 && !hs_a) begin
        hs_low++;
        if (first_low < 0) first_low = k;
      end
      if (k < 3200 && int'(hc_a) > hmax) hmax = int'(hc_a);
      if (k == 3199) begin
        chk("a_line_end_hCount", int'(hc_a), 799);
        chk("a_line_end_vCount", int'(vc_a), 0);
      end
      if (k == 3200) begin
        chk("a_line_wrap_hCount", int'(hc_a), 0);
        chk("a_line_wrap_vCount", int'(vc_a), 1);
      end
      @(negedge clk);
    end
    chk("a_hsync_low_clks", hs_low, 384);
    chk("a_hsync_first_low_clk", first_low, 4);
    chk("a_hCount_max", hmax, 799);

    // Small-timing instance: two full frames, then a mid-frame reset.
    chk("b_reset_hCount", int'(hc_b), 0);
    chk("b_reset_frame_tick", int'(ft_b), 0);
    rst_b = 1'b0;
    run_b(2 * B_FRAME + 8, 153, 1);
    for (int i = 0; i < 5; i++)
      chk($sformatf("b_window_seen %0d", i), win_seen[i], 1);

    found = 0;
    for (int n = 0; n < 2 * B_FRAME && found == 0; n++) begin
      if (int'(hc_b) == 10 && int'(vc_b) == 5) found = 1;
      else @(negedge clk);
    end
    chk("b_reach_mid_frame", found, 1);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    run_b(B_FRAME + 4, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
